// File: rtl/dma_pkg.sv
// Shared constants for the DMA channel scheduler: FSM encoding, default widths,
// and a constant-evaluable ceil(log2) helper.
package dma_pkg;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_AW     = 32;
    localparam int DEF_LW     = 32;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GRANT  = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after iPtr.
module rr_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IW     = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] iReq,
    input  logic [IW-1:0]     iPtr,
    output logic [NUM_CH-1:0] oGrant_onehot,
    output logic [IW-1:0]     oIdx
);
    always_comb begin
        oIdx = '0;
        // Scan farthest offset first so the closest requester to iPtr wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (iReq[(int'(iPtr) + i) % NUM_CH]) oIdx = IW'((int'(iPtr) + i) % NUM_CH);
        end
        oGrant_onehot = (|iReq) ? (NUM_CH'(1) << oIdx) : '0;
    end
endmodule

// File: rtl/dma_channel_scheduler.sv
// Round-robin owner of the shared DMA read/write masters: latches one channel's
// descriptor, strobes start, waits for write-master done or watchdog timeout.
module dma_channel_scheduler
    import dma_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int AW          = DEF_AW,
    parameter int LW          = DEF_LW,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 iClk,
    input  logic                 iReset,
    input  logic [NUM_CH-1:0]    iReq,
    input  logic [NUM_CH*AW-1:0] iRM_startaddress,
    input  logic [NUM_CH*AW-1:0] iWM_startaddress,
    input  logic [NUM_CH*LW-1:0] iLength,
    input  logic                 iMW_done,
    output logic                 oStart,
    output logic [AW-1:0]        oRM_startaddress,
    output logic [AW-1:0]        oWM_startaddress,
    output logic [LW-1:0]        oLength,
    output logic [NUM_CH-1:0]    oGrant,
    output logic [NUM_CH-1:0]    oDone,
    output logic [NUM_CH-1:0]    oError,
    output logic                 oBusy
);
    localparam int IW = clog2(NUM_CH);
    localparam int CW = (TIMEOUT_CYC == 0) ? 1 : clog2(TIMEOUT_CYC + 1);
    localparam bit WD_EN = (TIMEOUT_CYC != 0);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYC - 1);

    logic [2:0]        state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     curIdx;
    logic [IW-1:0]     arbIdx;
    logic [NUM_CH-1:0] arbOneHot;
    logic [CW-1:0]     wdCnt;
    logic              timedOut;

    rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) arb (
        .iReq          (iReq),
        .iPtr          (ptr),
        .oGrant_onehot (arbOneHot),
        .oIdx          (arbIdx)
    );

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state            <= ST_IDLE;
            ptr              <= '0;
            curIdx           <= '0;
            wdCnt            <= '0;
            timedOut         <= 1'b0;
            oGrant           <= '0;
            oRM_startaddress <= '0;
            oWM_startaddress <= '0;
            oLength          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|iReq) begin
                        oGrant           <= arbOneHot;
                        curIdx           <= arbIdx;
                        oRM_startaddress <= iRM_startaddress[int'(arbIdx)*AW +: AW];
                        oWM_startaddress <= iWM_startaddress[int'(arbIdx)*AW +: AW];
                        oLength          <= iLength[int'(arbIdx)*LW +: LW];
                        state            <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    timedOut <= 1'b0;
                    // Zero-length descriptors complete without touching the datapath.
                    state    <= (oLength == '0) ? ST_FINISH : ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    wdCnt <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (iMW_done) begin
                        state <= ST_FINISH;
                    end else if (WD_EN && wdCnt == WD_LAST) begin
                        timedOut <= 1'b1;
                        state    <= ST_FINISH;
                    end else if (wdCnt != '1) begin
                        wdCnt <= wdCnt + 1'b1;
                    end
                end
                ST_FINISH: begin
                    oGrant <= '0;
                    ptr    <= (curIdx == IW'(NUM_CH - 1)) ? '0 : curIdx + 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign oStart = (state == ST_LAUNCH);
    assign oDone  = (state == ST_FINISH && !timedOut) ? oGrant : '0;
    assign oError = (state == ST_FINISH &&  timedOut) ? oGrant : '0;
    assign oBusy  = (state != ST_IDLE);
endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Scenario bench for dma_channel_scheduler; a second instance with a short
// watchdog covers the timeout paths.
module tb_dma_channel_scheduler;
    typedef struct {
        int          ch;
        logic [31:0] rm;
        logic [31:0] wm;
        logic [31:0] len;
        bit          isErr;
    } exp_t;

    exp_t expQ[$];
    int total = 0;
    int bad   = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [127:0] rm  = '0;
    logic [127:0] wm  = '0;
    logic [127:0] len = '0;
    logic         mwDone = 1'b0;

    logic        start, busy, wStart, wBusy;
    logic [31:0] oRm, oWm, oLen, wRm, wWm, wLen;
    logic [3:0]  grant, done, err, wGrant, wDone, wErr;

    always #5 clk = ~clk;

    dma_channel_scheduler #(.NUM_CH(4), .AW(32), .LW(32), .TIMEOUT_CYC(65535)) dut (
        .iClk(clk), .iReset(rst), .iReq(req),
        .iRM_startaddress(rm), .iWM_startaddress(wm), .iLength(len),
        .iMW_done(mwDone), .oStart(start),
        .oRM_startaddress(oRm), .oWM_startaddress(oWm), .oLength(oLen),
        .oGrant(grant), .oDone(done), .oError(err), .oBusy(busy)
    );

    dma_channel_scheduler #(.NUM_CH(4), .AW(32), .LW(32), .TIMEOUT_CYC(8)) dutWd (
        .iClk(clk), .iReset(rst), .iReq(req),
        .iRM_startaddress(rm), .iWM_startaddress(wm), .iLength(len),
        .iMW_done(mwDone), .oStart(wStart),
        .oRM_startaddress(wRm), .oWM_startaddress(wWm), .oLength(wLen),
        .oGrant(wGrant), .oDone(wDone), .oError(wErr), .oBusy(wBusy)
    );

    task automatic setDesc(input int ch, input logic [31:0] r, input logic [31:0] w, input logic [31:0] l);
        rm[ch*32 +: 32]  = r;
        wm[ch*32 +: 32]  = w;
        len[ch*32 +: 32] = l;
    endtask

    task automatic doReset;
        rst = 1'b1; req = '0; mwDone = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1; req = '0; mwDone = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({grant, start, done, err, busy} !== 14'd0) begin
            bad++; $display("FAIL reset_ctrl: got g=%b s=%b d=%b e=%b b=%b want all 0", grant, start, done, err, busy);
        end
        total++;
        if ({oRm, oWm, oLen} !== 96'd0) begin
            bad++; $display("FAIL reset_desc: got %h %h %h want 0", oRm, oWm, oLen);
        end
        rst = 1'b0;
        setDesc(1, 32'h1000, 32'h2000, 32'd16);
        req = 4'b0010;
        n = 0;
        while (start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        total++;
        if (start !== 1'b1) begin bad++; $display("FAIL reset_start_timeout: got start=%b want 1", start); end
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL reset_midwait_busy: got %b want 1", busy); end
        rst = 1'b1; req = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (done !== 4'd0 || err !== 4'd0) begin
                bad++; $display("FAIL reset_abort_pulse: got d=%b e=%b want 0", done, err);
            end
        end
        total++;
        if ({grant, start, busy, oRm, oWm, oLen} !== 102'd0) begin
            bad++; $display("FAIL reset_abort_state: got g=%b s=%b b=%b rm=%h want all 0", grant, start, busy, oRm);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_after: got %b want 0", busy); end
    endtask

    task automatic test_single;
        exp_t e;
        int extraStart, earlyDone;
        doReset;
        for (int c = 0; c < 4; c++) setDesc(c, $urandom, $urandom, $urandom);
        setDesc(1, 32'h1000, 32'h2000, 32'd16);
        expQ.push_back('{1, 32'h1000, 32'h2000, 32'd16, 1'b0});
        req = 4'b0010;
        @(negedge clk);
        e = expQ.pop_front();
        total++;
        if (grant !== 4'(1 << e.ch) || start !== 1'b0) begin
            bad++; $display("FAIL single_grant: got g=%b s=%b want g=%b s=0", grant, start, 4'(1 << e.ch));
        end
        setDesc(1, 32'hDEAD0000, 32'hBEEF0000, 32'd99);
        @(negedge clk);
        total++;
        if (start !== 1'b1) begin bad++; $display("FAIL single_start: got %b want 1", start); end
        total++;
        if (oRm !== e.rm || oWm !== e.wm || oLen !== e.len) begin
            bad++; $display("FAIL single_desc: got %h %h %h want %h %h %h", oRm, oWm, oLen, e.rm, e.wm, e.len);
        end
        extraStart = 0; earlyDone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (start !== 1'b0) extraStart++;
            if (done !== 4'd0 || err !== 4'd0) earlyDone++;
        end
        total++;
        if (extraStart != 0 || earlyDone != 0) begin
            bad++; $display("FAIL single_wait: got extraStart=%0d earlyDone=%0d want 0 0", extraStart, earlyDone);
        end
        mwDone = 1'b1;
        @(negedge clk);
        mwDone = 1'b0;
        total++;
        if (done !== 4'b0010 || err !== 4'd0) begin
            bad++; $display("FAIL single_done: got d=%b e=%b want d=0010 e=0000", done, err);
        end
        req = '0;
        @(negedge clk);
        total++;
        if (done !== 4'd0 || grant !== 4'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_idle: got d=%b g=%b b=%b want 0", done, grant, busy);
        end
        total++;
        if (oRm !== e.rm || oWm !== e.wm || oLen !== e.len) begin
            bad++; $display("FAIL single_hold: got %h %h %h want %h %h %h", oRm, oWm, oLen, e.rm, e.wm, e.len);
        end
    endtask

    task automatic test_round_robin;
        exp_t cur;
        int cd, cyc, doneTot;
        int doneCnt[4];
        logic [3:0] prevGrant;
        doReset;
        for (int c = 0; c < 4; c++) begin
            setDesc(c, 32'h10000 * (c + 1), 32'h20000 * (c + 1), 32'(4 * (c + 1)));
            expQ.push_back('{c, 32'h10000 * (c + 1), 32'h20000 * (c + 1), 32'(4 * (c + 1)), 1'b0});
            doneCnt[c] = 0;
        end
        cur = '{-1, 32'd0, 32'd0, 32'd0, 1'b0};
        cd = 0; cyc = 0; doneTot = 0; prevGrant = '0;
        req = 4'hF;
        while (doneTot < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            mwDone = 1'b0;
            if (grant !== 4'd0 && grant !== prevGrant) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++; $display("FAIL rr_extra_grant: got %b want none", grant);
                end else begin
                    cur = expQ.pop_front();
                    if (grant !== 4'(1 << cur.ch)) begin
                        bad++; $display("FAIL rr_grant: got %b want %b", grant, 4'(1 << cur.ch));
                    end
                end
            end
            prevGrant = grant;
            if (start === 1'b1) begin
                total++;
                if (oRm !== cur.rm || oWm !== cur.wm || oLen !== cur.len) begin
                    bad++; $display("FAIL rr_desc ch%0d: got %h %h %h want %h %h %h", cur.ch, oRm, oWm, oLen, cur.rm, cur.wm, cur.len);
                end
                cd = 5;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) mwDone = 1'b1;
            end
            if (done !== 4'd0) begin
                total++;
                if (done !== 4'(1 << cur.ch)) begin
                    bad++; $display("FAIL rr_done: got %b want %b", done, 4'(1 << cur.ch));
                end
                for (int c = 0; c < 4; c++) if (done[c]) begin doneCnt[c]++; req[c] = 1'b0; end
                doneTot++;
            end
        end
        mwDone = 1'b0;
        total++;
        if (doneTot < 4) begin bad++; $display("FAIL rr_timeout: got %0d dones want 4", doneTot); end
        for (int c = 0; c < 4; c++) begin
            total++;
            if (doneCnt[c] != 1) begin bad++; $display("FAIL rr_done_count ch%0d: got %0d want 1", c, doneCnt[c]); end
        end
        total++;
        if (expQ.size() != 0) begin bad++; $display("FAIL rr_queue: got %0d left want 0", expQ.size()); expQ.delete(); end
        req = 4'hF;
        repeat (2) @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL rr_ptr_wrap: got %b want 0001", grant); end
        req = '0;
    endtask

    task automatic test_zero_len;
        exp_t e;
        int startSeen;
        doReset;
        setDesc(2, 32'h3000, 32'h4000, 32'd0);
        expQ.push_back('{2, 32'h3000, 32'h4000, 32'd0, 1'b0});
        req = 4'b0100;
        @(negedge clk);
        e = expQ.pop_front();
        startSeen = (start === 1'b1) ? 1 : 0;
        total++;
        if (grant !== 4'(1 << e.ch)) begin bad++; $display("FAIL zlen_grant: got %b want %b", grant, 4'(1 << e.ch)); end
        @(negedge clk);
        if (start === 1'b1) startSeen++;
        total++;
        if (done !== 4'b0100 || err !== 4'd0) begin bad++; $display("FAIL zlen_done: got d=%b e=%b want 0100 0000", done, err); end
        req = '0;
        @(negedge clk);
        if (start === 1'b1) startSeen++;
        total++;
        if (startSeen != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL zlen_nostart: got starts=%0d busy=%b want 0 0", startSeen, busy);
        end
    endtask

    task automatic test_watchdog;
        exp_t e;
        int n;
        doReset;
        setDesc(3, 32'h5000, 32'h6000, 32'd64);
        expQ.push_back('{3, 32'h5000, 32'h6000, 32'd64, 1'b1});
        req = 4'b1000;
        n = 0;
        while (wStart !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        e = expQ.pop_front();
        total++;
        if (wStart !== 1'b1 || wGrant !== 4'(1 << e.ch)) begin
            bad++; $display("FAIL wd_launch: got s=%b g=%b want 1 %b", wStart, wGrant, 4'(1 << e.ch));
        end
        n = 0;
        while (wErr === 4'd0 && wDone === 4'd0 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (wErr !== 4'(1 << e.ch) || wDone !== 4'd0 || n != 9) begin
            bad++; $display("FAIL wd_error: got e=%b d=%b after %0d want e=%b d=0000 after 9", wErr, wDone, n, 4'(1 << e.ch));
        end
        req = '0;
        @(negedge clk);
        expQ.push_back('{3, 32'h5000, 32'h6000, 32'd64, 1'b0});
        req = 4'b1000;
        n = 0;
        while (wStart !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        e = expQ.pop_front();
        repeat (8) @(negedge clk);
        mwDone = 1'b1;
        @(negedge clk);
        mwDone = 1'b0;
        total++;
        if (wDone !== 4'(1 << e.ch) || wErr !== 4'd0) begin
            bad++; $display("FAIL wd_tie: got d=%b e=%b want d=%b e=0000", wDone, wErr, 4'(1 << e.ch));
        end
        req = '0;
    endtask

    task automatic test_ignore;
        exp_t e;
        int n;
        doReset;
        mwDone = 1'b1;
        @(negedge clk);
        mwDone = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 4'd0 || grant !== 4'd0) begin
            bad++; $display("FAIL ign_idle_done: got b=%b d=%b g=%b want 0", busy, done, grant);
        end
        setDesc(0, 32'h7000, 32'h8000, 32'd8);
        expQ.push_back('{0, 32'h7000, 32'h8000, 32'd8, 1'b0});
        req = 4'b0001;
        n = 0;
        while (start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        e = expQ.pop_front();
        total++;
        if (start !== 1'b1 || oRm !== e.rm) begin bad++; $display("FAIL ign_launch: got s=%b rm=%h want 1 %h", start, oRm, e.rm); end
        repeat (2) @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b1 || grant !== 4'b0001) begin
            bad++; $display("FAIL ign_drop_req: got b=%b g=%b want 1 0001", busy, grant);
        end
        mwDone = 1'b1;
        @(negedge clk);
        mwDone = 1'b0;
        total++;
        if (done !== 4'b0001) begin bad++; $display("FAIL ign_done: got %b want 0001", done); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || grant !== 4'd0) begin bad++; $display("FAIL ign_no_regrant: got b=%b g=%b want 0 0000", busy, grant); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_zero_len;
        test_watchdog;
        test_ignore;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
